// File: rtl/fifo_pkg.sv
`timescale 1ns/100ps
// fifo_pkg: shared defaults, width helper and status bundle for the FIFO controller.
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;

    // Smallest n with 2**n >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointer width carries one lap bit above the RAM address.
    localparam int FIFO_PTR_W = clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
    } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
`timescale 1ns/100ps
// fifo_ptr: wrapping binary pointer with enable and synchronous reset.
// The top bit is the lap bit; the low bits address the RAM directly.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int PTR_W = FIFO_PTR_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    // Advance by one per enabled edge; natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl_dp.sv
`timescale 1ns/100ps
// fifo_ctrl_dp: synchronous FIFO controller driving an async-read dual-port RAM.
// Show-ahead read path: the head word is presented combinationally from the RAM.
module fifo_ctrl_dp
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = FIFO_WIDTH,
    parameter  int DEPTH     = FIFO_DEPTH,
    parameter  int AFULL_TH  = DEPTH - 2,
    localparam int DEPTH_LOG = clog2(DEPTH)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [DEPTH_LOG:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 ovf_err,
    output logic                 udf_err,
    input  logic                 clr_err,
    output logic                 ram_we_n,
    output logic [DEPTH_LOG-1:0] ram_addr_wr,
    output logic [WIDTH-1:0]     ram_data_wr,
    output logic [DEPTH_LOG-1:0] ram_addr_rd,
    input  logic [WIDTH-1:0]     ram_data_rd
);

    localparam int PTR_W = DEPTH_LOG + 1;
    localparam logic [DEPTH_LOG:0] AFULL_LVL = (DEPTH_LOG + 1)'(AFULL_TH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    fifo_status_t     status;

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop),
        .ptr (rd_ptr)
    );

    // Status from registered pointers/count only, so no path from in_valid/out_ready.
    always_comb begin
        status             = '0;
        status.empty       = (wr_ptr == rd_ptr);
        status.full        = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                             (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
        status.almost_full = (count >= AFULL_LVL);
    end

    assign full        = status.full;
    assign empty       = status.empty;
    assign almost_full = status.almost_full;

    // Handshakes; a push into an empty FIFO is not visible for popping until the next cycle.
    always_comb begin
        in_ready  = !status.full && !rst;
        out_valid = !status.empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // RAM port drive: write lands on the same edge wr_ptr advances; read is show-ahead.
    always_comb begin
        ram_we_n    = ~push;
        ram_addr_wr = wr_ptr[DEPTH_LOG-1:0];
        ram_data_wr = in_data;
        ram_addr_rd = rd_ptr[DEPTH_LOG-1:0];
        out_data    = ram_data_rd;
    end

    // Occupancy register, kept in step with the pointer difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky misuse flags; a new event in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (in_valid && status.full) begin
                ovf_err <= 1'b1;
            end else if (clr_err) begin
                ovf_err <= 1'b0;
            end
            if (out_ready && status.empty) begin
                udf_err <= 1'b1;
            end else if (clr_err) begin
                udf_err <= 1'b0;
            end
        end
    end

    count_tracks_ptrs: assert property (@(posedge clk) disable iff (rst)
        count == PTR_W'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
`timescale 1ns/100ps
// tb_fifo_ctrl_dp: scoreboard bench for fifo_ctrl_dp with a behavioural async-read RAM.
module tb_fifo_ctrl_dp;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       ovf_err;
    logic       udf_err;
    logic       clr_err;
    logic       ram_we_n;
    logic [3:0] ram_addr_wr;
    logic [7:0] ram_data_wr;
    logic [3:0] ram_addr_rd;
    logic [7:0] ram_data_rd;

    logic [7:0] mem [16];

    int         total;
    int         bad;

    int         m_count;
    logic [7:0] sb [$];
    logic [3:0] m_wp;
    logic [3:0] m_rp;
    logic       m_ovf;
    logic       m_udf;
    logic       m_known;

    fifo_ctrl_dp dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err),
        .clr_err     (clr_err),
        .ram_we_n    (ram_we_n),
        .ram_addr_wr (ram_addr_wr),
        .ram_data_wr (ram_data_wr),
        .ram_addr_rd (ram_addr_rd),
        .ram_data_rd (ram_data_rd)
    );

    always @(posedge clk) begin
        if (!ram_we_n) mem[ram_addr_wr] <= ram_data_wr;
    end
    assign ram_data_rd = mem[ram_addr_rd];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check all outputs against the model, clock, update model.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic clr, input logic rs);
        logic m_push;
        logic m_pop;
        logic n_ovf;
        logic n_udf;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clr_err   = clr;
        rst       = rs;
        #1;
        m_push = iv && (m_count != 16) && !rs;
        m_pop  = ordy && (m_count != 0) && !rs;
        n_ovf  = (iv && m_count == 16) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        n_udf  = (ordy && m_count == 0) ? 1'b1 : (clr ? 1'b0 : m_udf);
        if (m_known) begin
            chk("count",     int'(count),       m_count);
            chk("full",      int'(full),        int'(m_count == 16));
            chk("empty",     int'(empty),       int'(m_count == 0));
            chk("afull",     int'(almost_full), int'(m_count >= 14));
            chk("out_valid", int'(out_valid),   int'(m_count != 0));
            chk("in_ready",  int'(in_ready),    int'((m_count != 16) && !rs));
            chk("we_n",      int'(ram_we_n),    int'(!m_push));
            chk("addr_wr",   int'(ram_addr_wr), int'(m_wp));
            chk("addr_rd",   int'(ram_addr_rd), int'(m_rp));
            chk("ovf",       int'(ovf_err),     int'(m_ovf));
            chk("udf",       int'(udf_err),     int'(m_udf));
            if (m_count != 0) chk("head", int'(out_data), int'(sb[0]));
        end
        @(posedge clk);
        #0.1;
        if (rs) begin
            m_count = 0;
            sb.delete();
            m_wp    = 4'd0;
            m_rp    = 4'd0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_pop) begin
                void'(sb.pop_front());
                m_rp = m_rp + 4'd1;
            end
            if (m_push) begin
                sb.push_back(id);
                m_wp = m_wp + 4'd1;
            end
            m_count = m_count + int'(m_push) - int'(m_pop);
            m_ovf   = n_ovf;
            m_udf   = n_udf;
        end
    endtask

    initial begin
        int p_in;
        int p_out;
        total     = 0;
        bad       = 0;
        m_count   = 0;
        m_wp      = 4'd0;
        m_rp      = 4'd0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
        m_known   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        clr_err   = 1'b0;

        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full), 0);
        chk("rst_we_n",  int'(ram_we_n), 1);

        // Fill to full with 0x10..0x1F, no pops.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(16 + i), 1'b0, 1'b0, 1'b0);
            if (i == 12) chk("afull_at13", int'(almost_full), 0);
            if (i == 13) chk("afull_at14", int'(almost_full), 1);
        end
        chk("fill_full",  int'(full), 1);
        chk("fill_count", int'(count), 16);

        // Overflow attempts, then set-beats-clear, then clear.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("ovf_set",   int'(ovf_err), 1);
        chk("ovf_count", int'(count), 16);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("ovf_prio", int'(ovf_err), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", int'(ovf_err), 0);

        // Drain in order.
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", int'(out_data), 16 + i);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", int'(empty), 1);

        // Underflow.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("udf_set",   int'(udf_err), 1);
        chk("udf_count", int'(count), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("udf_clr", int'(udf_err), 0);

        // Fall-through into an empty FIFO while the consumer is ready.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("ft_valid", int'(out_valid), 1);
        chk("ft_data",  int'(out_data), 8'hA5);
        chk("ft_count", int'(count), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("mrst_count", int'(count), 0);
        chk("mrst_empty", int'(empty), 1);
        chk("mrst_valid", int'(out_valid), 0);
        chk("mrst_we_n",  int'(ram_we_n), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("mrst_idle_valid", int'(out_valid), 0);
        cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("mrst_new_head", int'(out_data), 8'h44);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Steady occupancy of 5 with push+pop every cycle; pointers lap twice.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
        chk("conc_count", int'(count), 5);
        for (int i = 0; i < 5; i++) begin
            chk("conc_tail", int'(out_data), 8'h60 + 35 + i);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Random traffic with shifting push/pop bias.
        p_in  = 50;
        p_out = 50;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) begin
                p_in  = int'($urandom_range(20, 90));
                p_out = int'($urandom_range(20, 90));
            end
            cycle($urandom_range(0, 99) < p_in, 8'($urandom), $urandom_range(0, 99) < p_out,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 299) == 0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
